// File: rtl/flash_sequencer.sv
// flash_sequencer: on a score-update request, latch the new display value and
// blink it FLASHES times (off phase + on phase per blink), each phase timed by
// one timer_start/timer_done handshake with the external flash timer. When the
// blinking ends the new value is left lit and seq_done pulses for one cycle.
module flash_sequencer #(
    parameter int WIDTH   = 8,
    parameter int FLASHES = 3      // blink pairs per sequence, 1..15
) (
    input  logic             CLK_50MHZ,
    input  logic             RST,
    input  logic             trigger,
    input  logic [WIDTH-1:0] data_in,
    output logic             timer_start,
    input  logic             timer_done,
    output logic [WIDTH-1:0] disp_data,
    output logic             blank,
    output logic             busy,
    output logic             seq_done
);

    // ARM_* states last exactly one cycle and fire the timer; WAIT_* states
    // hold the phase until the timer reports done.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM_OFF  = 3'd1,
        WAIT_OFF = 3'd2,
        ARM_ON   = 3'd3,
        WAIT_ON  = 3'd4,
        FINISH   = 3'd5
    } state_t;

    // Count of the last blink pair; flash_cnt never goes beyond this value.
    localparam logic [3:0] LAST_FLASH = 4'(FLASHES - 1);

    state_t           state_q, state_d;
    logic [3:0]       flash_cnt_q, flash_cnt_d;
    logic [WIDTH-1:0] disp_q, disp_d;

    // State, blink counter and displayed value; reset clears everything at once.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values and simulation ordering cannot change the result.
    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            flash_cnt_q <= 4'd0;
            disp_q      <= '0;
        end else begin
            state_q     <= state_d;
            flash_cnt_q <= flash_cnt_d;
            disp_q      <= disp_d;
        end
    end

    // Next-state logic: phase sequencing plus trigger/retrigger handling.
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        flash_cnt_d = flash_cnt_q;
        disp_d      = disp_q;

        unique case (state_q)
            IDLE: begin
                // timer_done is meaningless here and deliberately ignored
                if (trigger) begin
                    state_d = ARM_OFF;
                end
            end
            ARM_OFF: begin
                state_d = WAIT_OFF;
            end
            WAIT_OFF: begin
                if (timer_done) begin
                    state_d = ARM_ON;
                end
            end
            ARM_ON: begin
                state_d = WAIT_ON;
            end
            WAIT_ON: begin
                if (timer_done) begin
                    if (flash_cnt_q == LAST_FLASH) begin
                        state_d = FINISH;
                    end else begin
                        state_d     = ARM_OFF;
                        flash_cnt_d = flash_cnt_q + 4'd1;
                    end
                end
            end
            FINISH: begin
                // A trigger landing on the last cycle chains straight into a
                // new sequence so busy never drops.
                state_d = trigger ? ARM_OFF : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A trigger in any state takes the new value and restarts the blink
        // count; a phase already in flight is left to complete on its own.
        if (trigger) begin
            disp_d      = data_in;
            flash_cnt_d = 4'd0;
        end
    end

    // Outputs decode the state register only, so nothing from an input
    // reaches an output without passing through a flop.
    assign timer_start = (state_q == ARM_OFF) || (state_q == ARM_ON);
    assign blank       = (state_q == ARM_OFF) || (state_q == WAIT_OFF);
    assign busy        = (state_q != IDLE);
    assign seq_done    = (state_q == FINISH);
    assign disp_data   = disp_q;

endmodule

// File: tb/tb_flash_sequencer.sv
// Bench for flash_sequencer: two instances (FLASHES=3 and FLASHES=1), each
// paired with a flash-timer model. A phase-level behavioural model predicts
// every output on every cycle; directed scenarios add hand-computed totals.
module tb_flash_sequencer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Stimulus
    logic [1:0]        trig = '0;
    logic [1:0]        spur = '0;      // injected spurious timer_done
    logic [1:0][W-1:0] din  = '0;
    int                fixed_delay [2];  // 0 = random timer delay

    // Timer model
    logic [1:0] tm_done = '0;
    int         tm_cnt [2] = '{0, 0};
    logic [1:0] tdone;
    assign tdone = tm_done | spur;

    // DUT outputs
    logic         ts0, ts1, blank0, blank1, busy0, busy1, sd0, sd1;
    logic [W-1:0] disp0, disp1;
    logic [1:0]   ts_v, busy_v, sd_v, blank_v;
    assign ts_v    = {ts1, ts0};
    assign busy_v  = {busy1, busy0};
    assign sd_v    = {sd1, sd0};
    assign blank_v = {blank1, blank0};

    flash_sequencer #(.WIDTH(W), .FLASHES(3)) u_dut0 (
        .CLK_50MHZ(clk), .RST(rst), .trigger(trig[0]), .data_in(din[0]),
        .timer_start(ts0), .timer_done(tdone[0]), .disp_data(disp0),
        .blank(blank0), .busy(busy0), .seq_done(sd0)
    );

    flash_sequencer #(.WIDTH(W), .FLASHES(1)) u_dut1 (
        .CLK_50MHZ(clk), .RST(rst), .trigger(trig[1]), .data_in(din[1]),
        .timer_start(ts1), .timer_done(tdone[1]), .disp_data(disp1),
        .blank(blank1), .busy(busy1), .seq_done(sd1)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a sequence is a series of phases alternating
    // off/on. Each phase has an age (0 = the cycle the timer is fired);
    // a timer_done seen at age >= 1 ends it. After the on phase of the
    // last pair one finishing cycle follows.
    // ------------------------------------------------------------------
    typedef struct packed {
        bit           busy;
        bit           fin;
        bit           off;
        int           age;
        int           pairs;   // pairs completed since the last trigger
        logic [W-1:0] data;
    } mdl_t;

    mdl_t mdl [2];

    function automatic int flashes_of(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic mdl_t model_step(input mdl_t m, input int f, input bit t,
                                        input bit done, input logic [W-1:0] d);
        mdl_t n = m;
        if (!m.busy || m.fin) begin
            if (t) begin
                n.busy = 1'b1; n.fin = 1'b0; n.off = 1'b1;
                n.age = 0; n.pairs = 0; n.data = d;
            end else begin
                n.busy = 1'b0; n.fin = 1'b0;
            end
        end else begin
            if (m.age > 0 && done) begin
                if (m.off) begin
                    n.off = 1'b0; n.age = 0;
                end else if (m.pairs + 1 >= f) begin
                    n.fin = 1'b1;
                end else begin
                    n.off = 1'b1; n.age = 0; n.pairs = m.pairs + 1;
                end
            end else begin
                n.age = (m.age < 100000) ? m.age + 1 : m.age;
            end
            if (t) begin
                n.data  = d;
                n.pairs = 0;
            end
        end
        return n;
    endfunction

    function automatic logic [W+3:0] expect_vec(input mdl_t m);
        return {m.busy, m.busy && !m.fin && m.off, m.busy && !m.fin && (m.age == 0),
                m.fin, m.data};
    endfunction

    function automatic logic [W+3:0] dut_vec(input int k);
        return (k == 0) ? {busy0, blank0, ts0, sd0, disp0} : {busy1, blank1, ts1, sd1, disp1};
    endfunction

    // Model advances on the same edges the DUT sees
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) mdl[k] <= '0;
            else     mdl[k] <= model_step(mdl[k], flashes_of(k), trig[k], tdone[k], din[k]);
        end
    end

    // Flash timer: timer_done pulses <delay> cycles after timer_start
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            tm_done[k] <= (tm_cnt[k] == 1);
            if (ts_v[k])
                tm_cnt[k] <= (fixed_delay[k] > 0) ? fixed_delay[k] : int'($urandom_range(1, 12));
            else if (tm_cnt[k] > 0)
                tm_cnt[k] <= tm_cnt[k] - 1;
        end
    end

    // Compare process plus running statistics for the directed checks
    int         busy_cnt  [2] = '{0, 0};
    int         start_cnt [2] = '{0, 0};
    int         sd_cnt    [2] = '{0, 0};
    int         sd_pos    [2] = '{0, 0};
    logic       blank_hist [8192];
    localparam int HMASK = 8191;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("outputs_dut%0d", k), 32'(dut_vec(k)), 32'(expect_vec(mdl[k])));
            if (busy_v[k]) busy_cnt[k] <= busy_cnt[k] + 1;
            if (ts_v[k])   start_cnt[k] <= start_cnt[k] + 1;
            if (sd_v[k]) begin
                sd_cnt[k] <= sd_cnt[k] + 1;
                sd_pos[k] <= busy_cnt[k] + 1;
            end
        end
        if (busy0) blank_hist[busy_cnt[0] & HMASK] <= blank0;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the falling edge)
    // ------------------------------------------------------------------
    task automatic step_cycle();
        @(negedge clk);
        #1;
    endtask

    // Leaves the caller in the first cycle after the trigger was sampled
    task automatic pulse_trig(input int k, input logic [W-1:0] d);
        step_cycle();
        trig[k] = 1'b1;
        din[k]  = d;
        step_cycle();
        trig[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n = 0;
        do begin
            step_cycle();
            n++;
        end while (busy_v[k] && n < budget);
        check($sformatf("idle_wait_dut%0d", k), 32'(busy_v[k]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int b0, s0, q0, n, bad;
        fixed_delay[0] = 8;
        fixed_delay[1] = 3;
        repeat (3) step_cycle();
        rst = 1'b0;
        step_cycle();

        // Reset and idle: reset lands mid-cycle while the sequence is armed
        pulse_trig(0, 8'hC3);
        check("latency_busy_blank_start", 32'({busy0, blank0, ts0}), 32'b111);
        #2 rst = 1'b1;
        #1 check("async_reset_mid_cycle", 32'(dut_vec(0)), 32'd0);
        step_cycle();
        rst = 1'b0;
        s0 = start_cnt[0]; b0 = busy_cnt[0];
        repeat (20) step_cycle();
        check("idle_no_timer_start", 32'(start_cnt[0] - s0), 32'd0);
        check("idle_no_busy", 32'(busy_cnt[0] - b0), 32'd0);

        // Basic sequence: 6 phases of 9 cycles plus one finishing cycle
        b0 = busy_cnt[0]; s0 = start_cnt[0]; q0 = sd_cnt[0];
        pulse_trig(0, 8'h2A);
        wait_idle(0, 200);
        check("basic_disp", 32'(disp0), 32'h2A);
        check("basic_starts", 32'(start_cnt[0] - s0), 32'd6);
        check("basic_busy_cycles", 32'(busy_cnt[0] - b0), 32'd55);
        check("basic_seq_done_pos", 32'(sd_pos[0] - b0), 32'd55);
        check("basic_seq_done_count", 32'(sd_cnt[0] - q0), 32'd1);
        bad = 0;
        for (int i = 0; i < 55; i++) begin
            if (blank_hist[(b0 + i) & HMASK] !== ((i < 54) && ((i / 9) % 2 == 0))) bad++;
        end
        check("basic_blank_pattern_errors", 32'(bad), 32'd0);
        check("basic_after_blank_busy", 32'({blank0, busy0}), 32'd0);

        // Spurious timer_done in IDLE, then in ARM_OFF
        spur[0] = 1'b1;
        step_cycle();
        spur[0] = 1'b0;
        step_cycle();
        check("spur_idle_busy", 32'(busy0), 32'd0);
        b0 = busy_cnt[0]; s0 = start_cnt[0];
        pulse_trig(0, 8'h3C);
        spur[0] = 1'b1;
        step_cycle();
        spur[0] = 1'b0;
        step_cycle();
        check("spur_arm_still_blank", 32'(blank0), 32'd1);
        wait_idle(0, 200);
        check("spur_busy_cycles", 32'(busy_cnt[0] - b0), 32'd55);
        check("spur_starts", 32'(start_cnt[0] - s0), 32'd6);

        // Retrigger in the on phase of the second pair. The count restarts
        // at 0 while that on phase is in flight, so it completes as pair 0
        // and two more pairs follow: 4 + 4 timer starts in total.
        s0 = start_cnt[0]; q0 = sd_cnt[0];
        pulse_trig(0, 8'h77);
        n = 0;
        while (!(mdl[0].busy && !mdl[0].fin && !mdl[0].off && mdl[0].pairs == 1 &&
                 mdl[0].age >= 2) && n < 200) begin
            step_cycle();
            n++;
        end
        check("retrig_reached_second_on", 32'(start_cnt[0] - s0), 32'd4);
        trig[0] = 1'b1;
        din[0]  = 8'h11;
        step_cycle();
        trig[0] = 1'b0;
        check("retrig_disp_next_cycle", 32'(disp0), 32'h11);
        check("retrig_no_extra_start", 32'({busy0, blank0, ts0}), 32'b100);
        wait_idle(0, 300);
        check("retrig_total_starts", 32'(start_cnt[0] - s0), 32'd8);
        check("retrig_single_seq_done", 32'(sd_cnt[0] - q0), 32'd1);

        // Reset in WAIT_OFF; the timer's pending done must then be ignored
        pulse_trig(0, 8'h99);
        step_cycle();
        step_cycle();
        #2 rst = 1'b1;
        #1 check("wait_off_reset", 32'(dut_vec(0)), 32'd0);
        step_cycle();
        rst = 1'b0;
        b0 = busy_cnt[0]; s0 = start_cnt[0];
        repeat (15) step_cycle();
        check("post_reset_no_busy", 32'(busy_cnt[0] - b0), 32'd0);
        check("post_reset_no_start", 32'(start_cnt[0] - s0), 32'd0);

        // FLASHES=1 with a trigger in the FINISH cycle
        b0 = busy_cnt[1]; s0 = start_cnt[1]; q0 = sd_cnt[1];
        pulse_trig(1, 8'h5A);
        n = 0;
        while (!mdl[1].fin && n < 50) begin
            step_cycle();
            n++;
        end
        check("f1_single_pair_starts", 32'(start_cnt[1] - s0), 32'd2);
        check("f1_finish_seq_done", 32'({busy1, sd1}), 32'b11);
        trig[1] = 1'b1;
        din[1]  = 8'hA5;
        step_cycle();
        trig[1] = 1'b0;
        check("f1_chain_outputs", 32'(dut_vec(1)), 32'({4'b1110, 8'hA5}));
        wait_idle(1, 50);
        check("f1_busy_no_gap", 32'(busy_cnt[1] - b0), 32'd18);
        check("f1_seq_done_count", 32'(sd_cnt[1] - q0), 32'd2);
        check("f1_total_starts", 32'(start_cnt[1] - s0), 32'd4);

        // Randomised traffic: random timer delays, triggers and spurious dones
        fixed_delay[0] = 0;
        fixed_delay[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            step_cycle();
            for (int k = 0; k < 2; k++) begin
                trig[k] = ($urandom_range(0, 39) == 0);
                din[k]  = W'($urandom);
                spur[k] = ($urandom_range(0, 24) == 0);
            end
        end
        step_cycle();
        trig = '0;
        spur = '0;
        wait_idle(0, 400);
        wait_idle(1, 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
